// File: rtl/idu_pkg.sv
// Shared decode definitions: opcodes, ALU operation codes, memory sizes and the
// control bundle carried by the decode output register.
package idu_pkg;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM32 = 7'b0011011;
  localparam logic [6:0] OP32     = 7'b0111011;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  // M ops are ordered by funct3 so AluMul + funct3 selects the operation.
  typedef enum logic [4:0] {
    AluAdd, AluSub, AluSll, AluSlt, AluSltu, AluXor, AluSrl, AluSra, AluOr, AluAnd,
    AluBeq, AluBne, AluBlt, AluBge, AluBltu, AluBgeu,
    AluMul, AluMulh, AluMulhsu, AluMulhu, AluDiv, AluDivu, AluRem, AluRemu
  } alu_op_e;

  typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ} fmt_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    alu_op_e    alu_op;
    logic       src1_pc;
    logic       src2_imm;
    logic       reg_wr;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] mem_size;
    logic       mem_uns;
    logic       branch;
    logic       jump;
    logic       word;
    logic       illegal;
    logic       ebreak;
  } ctrl_t;

endpackage

// File: rtl/idu_imm_gen.sv
// Immediate generator: extracts the format-specific immediate and sign-extends
// it from inst[31] to XLEN.
module idu_imm_gen
  import idu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [31:0]     inst,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (fmt)
      FmtI:    imm32 = {{20{inst[31]}}, inst[31:20]};
      FmtS:    imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FmtB:    imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FmtU:    imm32 = {inst[31:12], 12'b0};
      FmtJ:    imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  if (XLEN > 32) begin : g_ext
    assign imm = {{(XLEN-32){imm32[31]}}, imm32};
  end else begin : g_noext
    assign imm = imm32;
  end

endmodule

// File: rtl/idu_pipe.sv
// RV32I/RV64I(+M) decode stage: combinational decode into a single output
// register with valid/ready handshake on both sides and a flush for redirects.
module idu_pipe
  import idu_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter bit          EN_M    = 1'b0,
  parameter bit          ILL_NOP = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_alu_op,
  output logic            out_src1_pc,
  output logic            out_src2_imm,
  output logic            out_reg_wr,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic [1:0]      out_mem_size,
  output logic            out_mem_uns,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_word,
  output logic            out_illegal,
  output logic            out_ebreak
);

  localparam bit Rv32 = (XLEN == 32);

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic            word, shamt_bad, ill;
  fmt_e            fmt;
  ctrl_t           ctrl_d, ctrl_q;
  logic [XLEN-1:0] imm_d, imm_q, pc_q;

  assign opc  = in_inst[6:0];
  assign f3   = in_inst[14:12];
  assign f7   = in_inst[31:25];
  assign word = (opc == OP_IMM32) || (opc == OP32);
  // Shift amounts reach bit 5 only for full-width RV64 shifts.
  assign shamt_bad = in_inst[25] && (Rv32 || word);

  always_comb begin
    ctrl_d = '0;
    fmt    = FmtR;
    ill    = 1'b0;
    unique case (opc)
      LUI, AUIPC: begin
        fmt             = FmtU;
        ctrl_d.rd       = in_inst[11:7];
        ctrl_d.src1_pc  = (opc == AUIPC);
        ctrl_d.src2_imm = 1'b1;
        ctrl_d.reg_wr   = 1'b1;
      end
      JAL, JALR: begin
        fmt             = (opc == JAL) ? FmtJ : FmtI;
        ctrl_d.rs1      = (opc == JALR) ? in_inst[19:15] : 5'd0;
        ctrl_d.rd       = in_inst[11:7];
        ctrl_d.src1_pc  = 1'b1;
        ctrl_d.src2_imm = 1'b1;
        ctrl_d.reg_wr   = 1'b1;
        ctrl_d.jump     = 1'b1;
        ill             = (opc == JALR) && (f3 != 3'd0);
      end
      BRANCH: begin
        fmt           = FmtB;
        ctrl_d.rs1    = in_inst[19:15];
        ctrl_d.rs2    = in_inst[24:20];
        ctrl_d.branch = 1'b1;
        case (f3)
          3'd0:    ctrl_d.alu_op = AluBeq;
          3'd1:    ctrl_d.alu_op = AluBne;
          3'd4:    ctrl_d.alu_op = AluBlt;
          3'd5:    ctrl_d.alu_op = AluBge;
          3'd6:    ctrl_d.alu_op = AluBltu;
          3'd7:    ctrl_d.alu_op = AluBgeu;
          default: ill = 1'b1;
        endcase
      end
      LOAD: begin
        fmt             = FmtI;
        ctrl_d.rs1      = in_inst[19:15];
        ctrl_d.rd       = in_inst[11:7];
        ctrl_d.src2_imm = 1'b1;
        ctrl_d.reg_wr   = 1'b1;
        ctrl_d.mem_rd   = 1'b1;
        ctrl_d.mem_size = f3[1:0];
        ctrl_d.mem_uns  = f3[2];
        ill = (f3 == 3'd7) || (Rv32 && (f3 == 3'd3 || f3 == 3'd6));
      end
      STORE: begin
        fmt             = FmtS;
        ctrl_d.rs1      = in_inst[19:15];
        ctrl_d.rs2      = in_inst[24:20];
        ctrl_d.src2_imm = 1'b1;
        ctrl_d.mem_wr   = 1'b1;
        ctrl_d.mem_size = f3[1:0];
        ill = f3[2] || (Rv32 && f3 == 3'd3);
      end
      OP_IMM, OP_IMM32: begin
        fmt             = FmtI;
        ctrl_d.rs1      = in_inst[19:15];
        ctrl_d.rd       = in_inst[11:7];
        ctrl_d.src2_imm = 1'b1;
        ctrl_d.reg_wr   = 1'b1;
        ctrl_d.word     = word;
        ill             = word && Rv32;
        case (f3)
          3'd0: ctrl_d.alu_op = AluAdd;
          3'd1: begin
            ctrl_d.alu_op = AluSll;
            ill = ill || shamt_bad || (in_inst[31:26] != 6'b000000);
          end
          3'd5: begin
            ctrl_d.alu_op = in_inst[30] ? AluSra : AluSrl;
            ill = ill || shamt_bad ||
                  (in_inst[31:26] != 6'b000000 && in_inst[31:26] != 6'b010000);
          end
          3'd2: begin ctrl_d.alu_op = AluSlt;  ill = ill || word; end
          3'd3: begin ctrl_d.alu_op = AluSltu; ill = ill || word; end
          3'd4: begin ctrl_d.alu_op = AluXor;  ill = ill || word; end
          3'd6: begin ctrl_d.alu_op = AluOr;   ill = ill || word; end
          default: begin ctrl_d.alu_op = AluAnd; ill = ill || word; end
        endcase
      end
      OP, OP32: begin
        ctrl_d.rs1    = in_inst[19:15];
        ctrl_d.rs2    = in_inst[24:20];
        ctrl_d.rd     = in_inst[11:7];
        ctrl_d.reg_wr = 1'b1;
        ctrl_d.word   = word;
        ill           = word && Rv32;
        if (f7 == 7'b0000001) begin
          ctrl_d.alu_op = alu_op_e'(AluMul + {2'b00, f3});
          ill = ill || !EN_M || (word && f3 inside {3'd1, 3'd2, 3'd3});
        end else if (f7 == 7'b0000000) begin
          case (f3)
            3'd0:    ctrl_d.alu_op = AluAdd;
            3'd1:    ctrl_d.alu_op = AluSll;
            3'd2:    ctrl_d.alu_op = AluSlt;
            3'd3:    ctrl_d.alu_op = AluSltu;
            3'd4:    ctrl_d.alu_op = AluXor;
            3'd5:    ctrl_d.alu_op = AluSrl;
            3'd6:    ctrl_d.alu_op = AluOr;
            default: ctrl_d.alu_op = AluAnd;
          endcase
          ill = ill || (word && !(f3 inside {3'd0, 3'd1, 3'd5}));
        end else if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) begin
          ctrl_d.alu_op = (f3 == 3'd0) ? AluSub : AluSra;
        end else begin
          ill = 1'b1;
        end
      end
      SYSTEM: begin
        ctrl_d.ebreak = (in_inst == 32'h0010_0073);
        ill           = !ctrl_d.ebreak;
      end
      MISC_MEM: ill = (f3 != 3'd0);
      default:  ill = 1'b1;
    endcase
    if (in_inst[1:0] != 2'b11) ill = 1'b1;
    if (ctrl_d.rd == 5'd0) ctrl_d.reg_wr = 1'b0;
    ctrl_d.illegal = ill;
    if (ill && ILL_NOP) begin
      ctrl_d.reg_wr = 1'b0;
      ctrl_d.mem_rd = 1'b0;
      ctrl_d.mem_wr = 1'b0;
    end
  end

  idu_imm_gen #(
    .XLEN(XLEN)
  ) u_imm_gen (
    .inst(in_inst),
    .fmt (fmt),
    .imm (imm_d)
  );

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        ctrl_q <= ctrl_d;
        imm_q  <= imm_d;
        pc_q   <= in_pc;
      end
    end
  end

  assign out_pc       = pc_q;
  assign out_imm      = imm_q;
  assign out_rs1      = ctrl_q.rs1;
  assign out_rs2      = ctrl_q.rs2;
  assign out_rd       = ctrl_q.rd;
  assign out_alu_op   = ctrl_q.alu_op;
  assign out_src1_pc  = ctrl_q.src1_pc;
  assign out_src2_imm = ctrl_q.src2_imm;
  assign out_reg_wr   = ctrl_q.reg_wr;
  assign out_mem_rd   = ctrl_q.mem_rd;
  assign out_mem_wr   = ctrl_q.mem_wr;
  assign out_mem_size = ctrl_q.mem_size;
  assign out_mem_uns  = ctrl_q.mem_uns;
  assign out_branch   = ctrl_q.branch;
  assign out_jump     = ctrl_q.jump;
  assign out_word     = ctrl_q.word;
  assign out_illegal  = ctrl_q.illegal;
  assign out_ebreak   = ctrl_q.ebreak;

endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe: an RV64 and an RV32 instance share one stimulus
// stream; each step checks hand-computed decode results.
module tb_idu_pipe;
  import idu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  int          errors = 0;
  int          checks = 0;

  // RV64 instance outputs
  logic        a_in_ready, a_valid, a_src1_pc, a_src2_imm, a_reg_wr, a_mem_rd, a_mem_wr;
  logic        a_mem_uns, a_branch, a_jump, a_word, a_illegal, a_ebreak;
  logic [63:0] a_pc, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd, a_alu_op;
  logic [1:0]  a_mem_size;
  // RV32 instance outputs
  logic        b_in_ready, b_valid, b_src1_pc, b_src2_imm, b_reg_wr, b_mem_rd, b_mem_wr;
  logic        b_mem_uns, b_branch, b_jump, b_word, b_illegal, b_ebreak;
  logic [31:0] b_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd, b_alu_op;
  logic [1:0]  b_mem_size;

  idu_pipe #(.XLEN(64), .EN_M(1'b0), .ILL_NOP(1'b1)) u_rv64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(a_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_rs1(a_rs1), .out_rs2(a_rs2), .out_rd(a_rd), .out_imm(a_imm),
    .out_alu_op(a_alu_op), .out_src1_pc(a_src1_pc), .out_src2_imm(a_src2_imm),
    .out_reg_wr(a_reg_wr), .out_mem_rd(a_mem_rd), .out_mem_wr(a_mem_wr),
    .out_mem_size(a_mem_size), .out_mem_uns(a_mem_uns), .out_branch(a_branch),
    .out_jump(a_jump), .out_word(a_word), .out_illegal(a_illegal), .out_ebreak(a_ebreak)
  );

  idu_pipe #(.XLEN(32), .EN_M(1'b0), .ILL_NOP(1'b1)) u_rv32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(b_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_rs1(b_rs1), .out_rs2(b_rs2), .out_rd(b_rd), .out_imm(b_imm),
    .out_alu_op(b_alu_op), .out_src1_pc(b_src1_pc), .out_src2_imm(b_src2_imm),
    .out_reg_wr(b_reg_wr), .out_mem_rd(b_mem_rd), .out_mem_wr(b_mem_wr),
    .out_mem_size(b_mem_size), .out_mem_uns(b_mem_uns), .out_branch(b_branch),
    .out_jump(b_jump), .out_word(b_word), .out_illegal(b_illegal), .out_ebreak(b_ebreak)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] inst, input logic [63:0] pc);
    in_inst  = inst;
    in_pc    = pc;
    in_valid = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_inst = 32'h0; in_pc = 64'h0;
    #12;
    chk("reset_valid", a_valid, 0);
    chk("reset_imm", a_imm, 0);
    chk("reset_rd", a_rd, 0);
    chk("reset_reg_wr", a_reg_wr, 0);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", a_in_ready, 1);

    // addi x1,x2,-1
    issue(32'hfff1_0093, 64'h1000);
    in_valid = 1'b0;
    chk("addi_valid", a_valid, 1);
    chk("addi_rs1", a_rs1, 2);
    chk("addi_rd", a_rd, 1);
    chk("addi_imm", a_imm, 64'hffff_ffff_ffff_ffff);
    chk("addi_alu", a_alu_op, AluAdd);
    chk("addi_src2_imm", a_src2_imm, 1);
    chk("addi_reg_wr", a_reg_wr, 1);
    chk("addi_pc", a_pc, 64'h1000);
    step();
    chk("handoff_valid", a_valid, 0);

    // beq x1,x2,-4 held under back-pressure, lui x5,0x80000 waiting
    out_ready = 1'b0;
    issue(32'hfe20_8ee3, 64'h2000);
    in_inst = 32'h8000_02b7;
    in_pc   = 64'h2004;
    #1;
    chk("stall_in_ready", a_in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      chk("beq_valid", a_valid, 1);
      chk("beq_imm", a_imm, 64'hffff_ffff_ffff_fffc);
      chk("beq_branch", a_branch, 1);
      chk("beq_alu", a_alu_op, AluBeq);
      chk("beq_pc", a_pc, 64'h2000);
      if (i < 2) step();
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", a_in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("lui_valid", a_valid, 1);
    chk("lui_pc", a_pc, 64'h2004);
    chk("lui_imm", a_imm, 64'hffff_ffff_8000_0000);
    chk("lui_rd", a_rd, 5);
    chk("lui_branch", a_branch, 0);
    chk("lui_reg_wr", a_reg_wr, 1);
    step();
    chk("lui_drain", a_valid, 0);

    // addiw: illegal on RV32, legal word op on RV64
    issue(32'h0010_009b, 64'h3000);
    chk("addiw32_illegal", b_illegal, 1);
    chk("addiw32_reg_wr", b_reg_wr, 0);
    chk("addiw64_illegal", a_illegal, 0);
    chk("addiw64_word", a_word, 1);
    // sd x2,0(x1)
    issue(32'h0020_b023, 64'h3004);
    chk("sd32_illegal", b_illegal, 1);
    chk("sd32_mem_wr", b_mem_wr, 0);
    chk("sd64_mem_wr", a_mem_wr, 1);
    chk("sd64_size", a_mem_size, MEM_D);
    // slli x1,x1,32
    issue(32'h0200_9093, 64'h3008);
    chk("slli32_illegal", b_illegal, 1);
    chk("slli64_illegal", a_illegal, 0);
    chk("slli64_imm", a_imm, 32);
    chk("slli64_alu", a_alu_op, AluSll);
    // addi x0,x0,5
    issue(32'h0050_0013, 64'h300c);
    chk("addi_x0_reg_wr", a_reg_wr, 0);
    chk("addi_x0_illegal", a_illegal, 0);
    // ebreak
    issue(32'h0010_0073, 64'h3010);
    chk("ebreak", a_ebreak, 1);
    chk("ebreak_illegal", a_illegal, 0);
    // mul x1,x1,x2 with EN_M=0
    issue(32'h0220_80b3, 64'h3014);
    chk("mul_illegal", a_illegal, 1);
    chk("mul_reg_wr", a_reg_wr, 0);
    // ecall
    issue(32'h0000_0073, 64'h3018);
    chk("ecall_illegal", a_illegal, 1);
    chk("ecall_ebreak", a_ebreak, 0);
    // addi encoding with inst[1:0]=00
    issue(32'hfff1_0090, 64'h301c);
    chk("quadrant_illegal", a_illegal, 1);
    // jal x1,+8
    issue(32'h0080_00ef, 64'h3020);
    chk("jal_imm", a_imm, 8);
    chk("jal_jump", a_jump, 1);
    chk("jal_src1_pc", a_src1_pc, 1);
    chk("jal_rd", a_rd, 1);
    // lbu x3,-1(x2)
    issue(32'hfff1_4183, 64'h3024);
    chk("lbu_mem_rd", a_mem_rd, 1);
    chk("lbu_uns", a_mem_uns, 1);
    chk("lbu_size", a_mem_size, MEM_B);
    chk("lbu_imm", a_imm, 64'hffff_ffff_ffff_ffff);
    chk("lbu32_imm", b_imm, 64'hffff_ffff);
    in_valid = 1'b0;
    step();

    // Flush while a bundle is held and a new instruction is offered
    issue(32'hfff1_0093, 64'h4000);
    chk("pre_flush_valid", a_valid, 1);
    out_ready = 1'b0;
    flush     = 1'b1;
    in_inst   = 32'h8000_02b7;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", a_valid, 0);
    step();
    chk("flush_dropped", a_valid, 0);

    // Asynchronous reset during a stall
    issue(32'hfff1_0093, 64'h5000);
    in_valid = 1'b0;
    chk("stall_valid", a_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", a_valid, 0);
    chk("async_rst_rd", a_rd, 0);
    chk("async_rst_imm", a_imm, 0);
    chk("async_rst_pc", a_pc, 0);
    chk("async_rst_reg_wr", a_reg_wr, 0);
    chk("async_rst32_valid", b_valid, 0);
    #2;
    rst = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
